// File: rtl/btn_evt_arb.sv
// btn_evt_arb: free-running CE prescaler plus round-robin arbiter for four button press events
module btn_evt_arb #(
    parameter int CE_DIV = 50000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] BTN_EVT,
    output logic       CE_O,
    output logic       EVT_VLD,
    input  logic       EVT_RDY,
    output logic [1:0] EVT_ID,
    output logic [3:0] PEND,
    output logic       EVT_OVF,
    input  logic       OVF_CLR
);
    localparam logic [0:0]  IDLE    = 1'b0;
    localparam logic [0:0]  OFFER   = 1'b1;
    localparam logic [19:0] CE_LAST = 20'(CE_DIV - 1);
    logic [19:0] cnt;
    logic [0:0]  state;
    logic [1:0]  rr_ptr;
    logic [1:0]  off;
    logic [1:0]  win;
    logic [7:0]  dbl;
    logic [3:0]  clr;
    logic        hs;
    logic        ovf_set;
    assign CE_O    = cnt == CE_LAST;
    assign EVT_VLD = state == OFFER;
    assign hs      = EVT_VLD & EVT_RDY;
    assign clr     = hs ? 4'b0001 << EVT_ID : 4'b0000;
    assign ovf_set = |(BTN_EVT & PEND & ~clr);
    // rotate PEND so bit 0 is the RR_PTR slot; the first set bit is the offset of the winner
    assign dbl     = {PEND, PEND} >> rr_ptr;
    assign off     = dbl[0] ? 2'd0 : dbl[1] ? 2'd1 : dbl[2] ? 2'd2 : 2'd3;
    assign win     = rr_ptr + off;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt     <= '0;
            PEND    <= '0;
            EVT_OVF <= 1'b0;
            state   <= IDLE;
            EVT_ID  <= '0;
            rr_ptr  <= '0;
        end else begin
            cnt     <= CE_O ? '0 : cnt + 20'd1;
            PEND    <= (PEND & ~clr) | BTN_EVT;
            EVT_OVF <= ovf_set | (EVT_OVF & ~OVF_CLR);
            if (state == IDLE && PEND != '0) begin
                state  <= OFFER;
                EVT_ID <= win;
            end else if (hs) begin
                state  <= IDLE;
                rr_ptr <= EVT_ID + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_btn_evt_arb.sv
// tb_btn_evt_arb: directed table-driven checks of the prescaler, arbiter, overflow and reset behaviour
module tb_btn_evt_arb;
    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [3:0] BTN_EVT = '0;
    logic       EVT_RDY = 1'b0;
    logic       OVF_CLR = 1'b0;
    logic       CE_O;
    logic       EVT_VLD;
    logic [1:0] EVT_ID;
    logic [3:0] PEND;
    logic       EVT_OVF;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic       rst_n;
        logic [3:0] btn;
        logic       rdy;
        logic       clr;
        logic       vld;
        logic [1:0] id;
        logic [3:0] pend;
        logic       ovf;
    } vec_t;

    vec_t tbl[$];

    btn_evt_arb #(.CE_DIV(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .BTN_EVT(BTN_EVT), .CE_O(CE_O), .EVT_VLD(EVT_VLD),
        .EVT_RDY(EVT_RDY), .EVT_ID(EVT_ID), .PEND(PEND), .EVT_OVF(EVT_OVF), .OVF_CLR(OVF_CLR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic r, input logic [3:0] b, input logic rd, input logic c,
                               input logic vl, input logic [1:0] i, input logic [3:0] p, input logic o);
        vec_t t;
        t.rst_n = r; t.btn = b; t.rdy = rd; t.clr = c;
        t.vld = vl; t.id = i; t.pend = p; t.ovf = o;
        return t;
    endfunction

    initial begin
        // reset values with RST_N held low
        tick();
        tick();
        chk("rst_ce", 8'(CE_O), 8'h0);
        chk("rst_vld", 8'(EVT_VLD), 8'h0);
        chk("rst_id", 8'(EVT_ID), 8'h0);
        chk("rst_pend", 8'(PEND), 8'h0);
        chk("rst_ovf", 8'(EVT_OVF), 8'h0);
        RST_N = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            tick();
            chk($sformatf("ce_edge%0d", e), 8'(CE_O), 8'((e % 4) == 3));
        end

        tbl.push_back(v(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 0));
        tbl.push_back(v(1, 4'b0100, 1, 0, 0, 0, 4'b0100, 0));
        tbl.push_back(v(1, 4'b0000, 1, 0, 1, 2, 4'b0100, 0));
        tbl.push_back(v(1, 4'b0000, 1, 0, 0, 2, 4'b0000, 0));
        tbl.push_back(v(1, 4'b0000, 1, 0, 0, 2, 4'b0000, 0));
        tbl.push_back(v(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 0));
        tbl.push_back(v(1, 4'b1011, 1, 0, 0, 0, 4'b1011, 0));
        tbl.push_back(v(1, 4'b0000, 1, 0, 1, 0, 4'b1011, 0));
        tbl.push_back(v(1, 4'b0000, 1, 0, 0, 0, 4'b1010, 0));
        tbl.push_back(v(1, 4'b0000, 1, 0, 1, 1, 4'b1010, 0));
        tbl.push_back(v(1, 4'b0000, 1, 0, 0, 1, 4'b1000, 0));
        tbl.push_back(v(1, 4'b0000, 1, 0, 1, 3, 4'b1000, 0));
        tbl.push_back(v(1, 4'b0000, 1, 0, 0, 3, 4'b0000, 0));
        tbl.push_back(v(1, 4'b0000, 1, 0, 0, 3, 4'b0000, 0));
        tbl.push_back(v(1, 4'b0010, 0, 0, 0, 3, 4'b0010, 0));
        tbl.push_back(v(1, 4'b0000, 0, 0, 1, 1, 4'b0010, 0));
        tbl.push_back(v(1, 4'b0010, 0, 0, 1, 1, 4'b0010, 1));
        tbl.push_back(v(1, 4'b0001, 0, 0, 1, 1, 4'b0011, 1));
        tbl.push_back(v(1, 4'b0000, 0, 1, 1, 1, 4'b0011, 0));
        tbl.push_back(v(1, 4'b0010, 0, 1, 1, 1, 4'b0011, 1));
        tbl.push_back(v(1, 4'b0000, 0, 1, 1, 1, 4'b0011, 0));
        tbl.push_back(v(1, 4'b0010, 1, 0, 0, 1, 4'b0011, 0));
        tbl.push_back(v(1, 4'b0000, 1, 0, 1, 0, 4'b0011, 0));
        tbl.push_back(v(1, 4'b0000, 1, 0, 0, 0, 4'b0010, 0));
        tbl.push_back(v(1, 4'b0000, 0, 0, 1, 1, 4'b0010, 0));
        tbl.push_back(v(1, 4'b0000, 1, 0, 0, 1, 4'b0000, 0));
        tbl.push_back(v(1, 4'b1100, 0, 0, 0, 1, 4'b1100, 0));
        tbl.push_back(v(1, 4'b0000, 0, 0, 1, 2, 4'b1100, 0));

        foreach (tbl[n]) begin
            RST_N = tbl[n].rst_n;
            BTN_EVT = tbl[n].btn;
            EVT_RDY = tbl[n].rdy;
            OVF_CLR = tbl[n].clr;
            tick();
            chk($sformatf("row%0d_vld", n), 8'(EVT_VLD), 8'(tbl[n].vld));
            chk($sformatf("row%0d_id", n), 8'(EVT_ID), 8'(tbl[n].id));
            chk($sformatf("row%0d_pend", n), 8'(PEND), 8'(tbl[n].pend));
            chk($sformatf("row%0d_ovf", n), 8'(EVT_OVF), 8'(tbl[n].ovf));
        end

        // asynchronous reset in the middle of an offer, observed before any clock edge
        BTN_EVT = '0;
        EVT_RDY = 1'b0;
        OVF_CLR = 1'b0;
        #2;
        RST_N = 1'b0;
        #1;
        chk("async_vld", 8'(EVT_VLD), 8'h0);
        chk("async_pend", 8'(PEND), 8'h0);
        chk("async_id", 8'(EVT_ID), 8'h0);
        chk("async_ovf", 8'(EVT_OVF), 8'h0);
        tick();
        tick();
        RST_N = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("post_rst%0d_vld", k), 8'(EVT_VLD), 8'h0);
            chk($sformatf("post_rst%0d_pend", k), 8'(PEND), 8'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/btn_evt_arb.md
BTN_EVT_ARB -- requirements
Module: btn_evt_arb

Interface
REQ-001 Parameter CE_DIV, default 50000: CE tick period in CLK cycles, legal range 2..2^20.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 BTN_EVT  input  4  single-cycle press strobes from four button filters, bit i = button i.
REQ-005 CE_O  output  1  clock-enable tick driven to all four button filters.
REQ-006 EVT_VLD  output  1  event available on EVT_ID.
REQ-007 EVT_RDY  input  1  consumer accepts event when high with EVT_VLD.
REQ-008 EVT_ID  output  2  index of the button whose event is offered.
REQ-009 PEND  output  4  pending-event flags, bit i = button i.
REQ-010 EVT_OVF  output  1  sticky overflow: a press was lost.
REQ-011 OVF_CLR  input  1  synchronous clear of EVT_OVF.

Function
REQ-012 Prescaler: 20-bit counter counts 0..CE_DIV-1 and wraps to 0; CE_O SHALL be 1 for exactly the cycle in which the counter equals CE_DIV-1.
REQ-013 Prescaler SHALL run free, independent of arbiter state and handshakes.
REQ-014 PEND[i] SHALL set on the edge where BTN_EVT[i]=1 and SHALL be visible the following cycle.
REQ-015 PEND[i] SHALL clear on the edge of an accepted handshake (EVT_VLD & EVT_RDY) with EVT_ID=i; if BTN_EVT[i]=1 on that same edge, PEND[i] SHALL remain set and no overflow is flagged.
REQ-016 Overflow: BTN_EVT[i]=1 while PEND[i]=1 and PEND[i] is not being cleared that cycle SHALL set EVT_OVF on that edge.
REQ-017 OVF_CLR=1 SHALL clear EVT_OVF; when set and clear coincide, set wins.
REQ-018 Arbiter FSM has two states, IDLE and OFFER; EVT_VLD=1 exactly in OFFER.
REQ-019 IDLE -> OFFER when PEND!=0; on that edge EVT_ID is loaded with the round-robin winner.
REQ-020 Round-robin: search starts at index RR_PTR and ascends modulo 4; the first set PEND bit wins.
REQ-021 OFFER: EVT_ID and EVT_VLD SHALL stay stable until EVT_RDY=1; EVT_RDY is ignored in IDLE.
REQ-022 OFFER -> IDLE on the handshake edge; RR_PTR <= (EVT_ID+1) mod 4 on that edge.
REQ-023 After each handshake the FSM SHALL spend at least one cycle in IDLE, so there are no back-to-back offers.
REQ-024 Latency: BTN_EVT[i] sampled at edge k with FSM idle and no other pending -> EVT_VLD=1 after edge k+1.
REQ-025 Strobes arriving while in OFFER SHALL only update PEND; they SHALL NOT alter the current EVT_ID.
REQ-026 Multiple BTN_EVT bits in one cycle SHALL all set their PEND bits.

Reset
REQ-027 RST_N=0 SHALL immediately force: prescaler=0, CE_O=0, PEND=0, EVT_OVF=0, EVT_VLD=0, EVT_ID=0, RR_PTR=0, FSM=IDLE.
REQ-028 Reset asserted during OFFER SHALL abort the offer with no handshake; all pending events are discarded.
REQ-029 After RST_N rises, the first CE_O SHALL occur CE_DIV cycles after the first active edge.

Verification
REQ-030 With CE_DIV=4 and no other stimulus, check that CE_O pulses one cycle in every 4, first pulse on the 4th edge after reset release.
REQ-031 Pulse BTN_EVT=4'b0100 with EVT_RDY=1 -> check EVT_VLD=1 with EVT_ID=2 two edges later, then PEND=0 and one IDLE cycle.
REQ-032 Pulse BTN_EVT=4'b1011 with EVT_RDY=1 and RR_PTR=0 -> check grants are IDs 0,1,3 in order with an IDLE cycle between each.
REQ-033 Hold EVT_RDY=0 in OFFER with ID=1, then pulse BTN_EVT[1] -> check EVT_OVF=1 and EVT_ID stays 1; pulse OVF_CLR -> check EVT_OVF=0.
REQ-034 Apply BTN_EVT[1] on the same edge as the handshake for ID=1 -> check PEND[1] stays 1, EVT_OVF stays 0, and ID 1 is re-offered.
REQ-035 Drive RST_N low mid-OFFER with PEND=4'b1100 -> check EVT_VLD=0 and PEND=0 without waiting for a CLK edge, and no offer after release.
